// File: rtl/cc_regfile_defs.sv
// Shared register-file constants, common to the read port and the write decoder.
package cc_regfile_defs;
    localparam int DATAWIDTH_SELECTION = 6;
    localparam int DATAWIDTH_BUS       = 32;
    localparam int NUM_REGS            = 38;
    localparam int ZERO_REG_INDEX      = 0;
endpackage

// File: rtl/cc_regfile_read_mux.sv
// One read lane: index -> register data, with same-cycle write forwarding
// and an out-of-range flag. Purely combinational.
module cc_regfile_read_mux
    import cc_regfile_defs::*;
#(
    parameter int SEL_W  = DATAWIDTH_SELECTION,
    parameter int BUS_W  = DATAWIDTH_BUS,
    parameter int N_REGS = NUM_REGS
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_REGS*BUS_W-1:0] regfile,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic                    wr_en,
    input  logic [BUS_W-1:0]        wr_data,
    output logic [BUS_W-1:0]        data,
    output logic                    range_err
);
    logic [N_REGS-1:0][BUS_W-1:0] regs;

    assign regs      = regfile;
    assign range_err = (sel >= SEL_W'(N_REGS));

    // Zero register and out-of-range indices fall through to the zero default;
    // a write landing on the selected register this edge wins over the stale slice.
    always_comb begin
        data = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (k != ZERO_REG_INDEX && sel == SEL_W'(k)) begin
                data = (wr_en && wr_sel == sel) ? wr_data : regs[k];
            end
        end
    end
endmodule

// File: rtl/cc_regfile_read_port.sv
// Dual read port of the register file: two read lanes feeding a single
// registered response slot with valid/ready handshakes on both sides.
module cc_regfile_read_port
    import cc_regfile_defs::*;
#(
    parameter int SEL_W  = DATAWIDTH_SELECTION,
    parameter int BUS_W  = DATAWIDTH_BUS,
    parameter int N_REGS = NUM_REGS
) (
    input  logic                    CC_RDPORT_CLOCK_50,
    input  logic                    CC_RDPORT_RESET_InLow,
    input  logic [SEL_W-1:0]        CC_RDPORT_SelA_In,
    input  logic [SEL_W-1:0]        CC_RDPORT_SelB_In,
    input  logic                    CC_RDPORT_ReqValid_In,
    output logic                    CC_RDPORT_ReqReady_Out,
    input  logic [N_REGS*BUS_W-1:0] CC_RDPORT_RegFile_In,
    input  logic [SEL_W-1:0]        CC_RDPORT_WrSel_In,
    input  logic                    CC_RDPORT_WrEn_In,
    input  logic [BUS_W-1:0]        CC_RDPORT_WrData_In,
    output logic [BUS_W-1:0]        CC_RDPORT_BusA_Out,
    output logic [BUS_W-1:0]        CC_RDPORT_BusB_Out,
    output logic                    CC_RDPORT_RspValid_Out,
    input  logic                    CC_RDPORT_RspReady_In,
    output logic                    CC_RDPORT_SelError_Out
);
    logic             rsp_valid;
    logic [BUS_W-1:0] bus_a, bus_b;
    logic             sel_err;
    logic [BUS_W-1:0] mux_a, mux_b;
    logic             err_a, err_b;
    logic             req_fire;

    cc_regfile_read_mux #(.SEL_W(SEL_W), .BUS_W(BUS_W), .N_REGS(N_REGS)) u_mux_a (
        .sel       (CC_RDPORT_SelA_In),
        .regfile   (CC_RDPORT_RegFile_In),
        .wr_sel    (CC_RDPORT_WrSel_In),
        .wr_en     (CC_RDPORT_WrEn_In),
        .wr_data   (CC_RDPORT_WrData_In),
        .data      (mux_a),
        .range_err (err_a)
    );

    cc_regfile_read_mux #(.SEL_W(SEL_W), .BUS_W(BUS_W), .N_REGS(N_REGS)) u_mux_b (
        .sel       (CC_RDPORT_SelB_In),
        .regfile   (CC_RDPORT_RegFile_In),
        .wr_sel    (CC_RDPORT_WrSel_In),
        .wr_en     (CC_RDPORT_WrEn_In),
        .wr_data   (CC_RDPORT_WrData_In),
        .data      (mux_b),
        .range_err (err_b)
    );

    // The slot frees up in the same cycle the consumer drains it, so a
    // steady RspReady gives one request per cycle with no bubbles.
    assign CC_RDPORT_ReqReady_Out = !rsp_valid || CC_RDPORT_RspReady_In;
    assign req_fire               = CC_RDPORT_ReqValid_In && CC_RDPORT_ReqReady_Out;

    // Response slot: capture on accept, otherwise hold the snapshot; draining
    // without a new request only clears valid and leaves the data in place.
    always_ff @(posedge CC_RDPORT_CLOCK_50 or negedge CC_RDPORT_RESET_InLow) begin
        if (!CC_RDPORT_RESET_InLow) begin
            rsp_valid <= 1'b0;
            bus_a     <= '0;
            bus_b     <= '0;
            sel_err   <= 1'b0;
        end else if (req_fire) begin
            rsp_valid <= 1'b1;
            bus_a     <= mux_a;
            bus_b     <= mux_b;
            sel_err   <= err_a || err_b;
        end else if (CC_RDPORT_RspReady_In) begin
            rsp_valid <= 1'b0;
        end
    end

    assign CC_RDPORT_RspValid_Out = rsp_valid;
    assign CC_RDPORT_BusA_Out     = bus_a;
    assign CC_RDPORT_BusB_Out     = bus_b;
    assign CC_RDPORT_SelError_Out = sel_err;
endmodule

// File: tb/tb_cc_regfile_read_port.sv
// Scoreboard bench for the register-file read port.
module tb_cc_regfile_read_port;
    localparam int SW = 6;
    localparam int BW = 32;
    localparam int NR = 38;

    typedef struct packed {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic          err;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [SW-1:0]         sel_a = '0, sel_b = '0, wr_sel = '0;
    logic                  req_valid = 1'b0, req_ready;
    logic [NR-1:0][BW-1:0] rf = '0;
    logic                  wr_en = 1'b0;
    logic [BW-1:0]         wr_data = '0;
    logic [BW-1:0]         bus_a, bus_b;
    logic                  rsp_valid, rsp_ready = 1'b1, sel_err;

    rsp_t q[$];
    rsp_t e;
    logic mvalid;
    int   n_chk = 0, n_fail = 0, n_rsp = 0;

    always #5 clk = ~clk;

    cc_regfile_read_port dut (
        .CC_RDPORT_CLOCK_50     (clk),
        .CC_RDPORT_RESET_InLow  (rst_n),
        .CC_RDPORT_SelA_In      (sel_a),
        .CC_RDPORT_SelB_In      (sel_b),
        .CC_RDPORT_ReqValid_In  (req_valid),
        .CC_RDPORT_ReqReady_Out (req_ready),
        .CC_RDPORT_RegFile_In   (rf),
        .CC_RDPORT_WrSel_In     (wr_sel),
        .CC_RDPORT_WrEn_In      (wr_en),
        .CC_RDPORT_WrData_In    (wr_data),
        .CC_RDPORT_BusA_Out     (bus_a),
        .CC_RDPORT_BusB_Out     (bus_b),
        .CC_RDPORT_RspValid_Out (rsp_valid),
        .CC_RDPORT_RspReady_In  (rsp_ready),
        .CC_RDPORT_SelError_Out (sel_err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference read of one bus at the capture edge.
    function automatic logic [BW-1:0] ref_rd(input logic [SW-1:0] s);
        if (s == 0 || s >= SW'(NR)) return '0;
        if (wr_en && wr_sel == s) return wr_data;
        return rf[s];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [SW-1:0] a, input logic [SW-1:0] b);
        sel_a = a;
        sel_b = b;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
    endtask

    // Occupancy model; stimulus only raises req_valid when the slot can accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mvalid <= 1'b0;
        else if (req_valid) mvalid <= 1'b1;
        else if (rsp_ready) mvalid <= 1'b0;
    end

    // Mid-cycle monitor: handshake checks, pop on drain, push on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rsp_valid", rsp_valid, mvalid);
            chk("req_ready", req_ready, !mvalid || rsp_ready);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("q_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("bus_a", bus_a, e.a);
                    chk("bus_b", bus_b, e.b);
                    chk("sel_err", sel_err, e.err);
                    n_rsp++;
                end
            end
            if (req_valid)
                q.push_back(rsp_t'{a: ref_rd(sel_a), b: ref_rd(sel_b),
                                   err: (sel_a >= SW'(NR)) || (sel_b >= SW'(NR))});
        end
    end

    initial begin
        int n0;
        for (int k = 0; k < NR; k++) rf[k] = $urandom;

        // Reset state
        #2;
        chk("rst_bus_a", bus_a, 0);
        chk("rst_bus_b", bus_b, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_err", sel_err, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_ready", req_ready, 1);

        // Basic read
        rf[5]  = 32'hDEADBEEF;
        rf[37] = 32'h12345678;
        req(5, 37);
        chk("basic_a", bus_a, 32'hDEADBEEF);
        chk("basic_b", bus_b, 32'h12345678);
        chk("basic_err", sel_err, 0);

        // Zero register and out-of-range indices
        rf[0] = 32'hFFFFFFFF;
        req(0, 38);
        chk("range38_err", sel_err, 1);
        req(0, 63);
        req(37, 0);
        req(40, 1);

        // Same-cycle forwarding, including writes to index 0 and out of range
        rf[7]   = 32'h1;
        wr_en   = 1'b1;
        wr_sel  = 7;
        wr_data = 32'hA5A5A5A5;
        req(7, 7);
        chk("fwd_a", bus_a, 32'hA5A5A5A5);
        chk("fwd_b", bus_b, 32'hA5A5A5A5);
        wr_sel = 0;
        req(0, 7);
        wr_sel = 45;
        req(45, 8);
        wr_en = 1'b0;
        cyc();

        // Back-pressure with a write to the held register during the stall
        rf[3] = 32'h33;
        rsp_ready = 1'b0;
        req(3, 3);
        rf[3]   = 32'h44;
        wr_en   = 1'b1;
        wr_sel  = 3;
        wr_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            chk("stall_ready", req_ready, 0);
            chk("stall_bus_a", bus_a, 32'h33);
            cyc();
        end
        wr_en = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("release_ready", req_ready, 1);
        cyc();

        // Streaming, 16 back-to-back requests
        n0 = n_rsp;
        for (int i = 1; i <= 16; i++) req(SW'(i), SW'(17 - i));
        cyc();
        chk("stream_count", n_rsp - n0, 16);

        // Random mix of back-pressure, writes and indices
        for (int i = 0; i < 60; i++) begin
            rsp_ready = 1'($urandom);
            wr_en     = 1'($urandom);
            wr_sel    = SW'($urandom_range(0, 40));
            wr_data   = $urandom;
            rf[$urandom_range(0, NR - 1)] = $urandom;
            sel_a     = SW'($urandom_range(0, 63));
            sel_b     = ($urandom_range(0, 3) == 0) ? wr_sel : SW'($urandom_range(0, 40));
            req_valid = (!mvalid || rsp_ready) && ($urandom_range(0, 3) != 0);
            cyc();
        end
        req_valid = 1'b0;
        wr_en     = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("drain_empty", q.size(), 0);

        // Asynchronous reset with a response pending
        rsp_ready = 1'b0;
        req(5, 50);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_bus_a", bus_a, 0);
        chk("arst_bus_b", bus_b, 0);
        chk("arst_err", sel_err, 0);
        cyc();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        cyc();
        chk("arst_ready", req_ready, 1);
        req(2, 4);
        cyc();
        chk("final_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
